// File: rtl/jedro_1_mem_arbiter.sv
// Two-requester arbiter sharing a single-port, one-cycle-latency RAM between
// instruction fetch (IF) and load/store (LSU); LSU has priority, IF is starvation-bounded.
module jedro_1_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,

  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,

  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,

  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       limit_hit;
  logic       resp_if;
  logic       resp_lsu;

  assign limit_hit = (starve_cnt == LIMIT);

  // Grants are gated by rstn_i so nothing reaches the memory while in reset.
  always_comb begin
    if_gnt_o  = 1'b0;
    lsu_gnt_o = 1'b0;
    if (rstn_i) begin
      if (if_req_i && (!lsu_req_i || limit_hit)) begin
        if_gnt_o = 1'b1;
      end else if (lsu_req_i) begin
        lsu_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en_o    = if_gnt_o | lsu_gnt_o;
    mem_we_o    = lsu_gnt_o & lsu_we_i;
    mem_be_o    = (lsu_gnt_o && lsu_we_i) ? lsu_be_i : '1;
    mem_addr_o  = lsu_gnt_o ? lsu_addr_i : if_addr_i;
    mem_wdata_o = lsu_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_cnt <= '0;
    end else if (lsu_gnt_o && !limit_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_if  <= 1'b0;
      resp_lsu <= 1'b0;
    end else begin
      resp_if  <= if_gnt_o;
      resp_lsu <= lsu_gnt_o;
    end
  end

  assign if_rvalid_o  = resp_if;
  assign lsu_rvalid_o = resp_lsu;
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Scoreboard bench for jedro_1_mem_arbiter: directed scenarios plus randomized traffic
// against a behavioural RAM and a rule-level arbitration model.
module tb_jedro_1_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        lsu_req, lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
    .lsu_rdata_o(lsu_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Physical RAM, driven only by the DUT's memory port.
  logic [31:0] ram [128];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[8:2]];
      end
    end
  end

  // Reference memory image and arbitration model state.
  logic [31:0] ref_mem [128];
  int unsigned if_wait;
  logic        last_ei, last_el;

  typedef struct {
    logic        is_lsu;
    logic        is_read;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic pop_chk(input logic is_lsu, input logic [31:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_rvalid: got rvalid(lsu=%0d) expected none at %0t", is_lsu, $time);
    end else begin
      e = sb.pop_front();
      chk("rvalid_owner", is_lsu, e.is_lsu);
      if (e.is_read) chk(is_lsu ? "lsu_rdata" : "if_rdata", rdata, e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (if_rvalid)  pop_chk(1'b0, if_rdata);
      if (lsu_rvalid) pop_chk(1'b1, lsu_rdata);
    end
  end

  // Applies one cycle of stimulus at the falling edge, then checks the
  // combinational grant/memory outputs against the model and queues responses.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic lr, input logic lw, input logic [3:0] lb,
                      input logic [31:0] la, input logic [31:0] lwd);
    logic ei, el;
    exp_t e;
    @(negedge clk);
    rstn = rst; if_req = ir; if_addr = ia;
    lsu_req = lr; lsu_we = lw; lsu_be = lb; lsu_addr = la; lsu_wdata = lwd;
    #1;
    if (!rst) begin
      ei = 1'b0; el = 1'b0;
    end else begin
      ei = ir && (!lr || if_wait >= LIMIT);
      el = lr && !ei;
    end
    chk("if_gnt", if_gnt, ei);
    chk("lsu_gnt", lsu_gnt, el);
    chk("gnt_exclusive", if_gnt & lsu_gnt, 1'b0);
    chk("mem_en", mem_en, ei | el);
    if (!rst) begin
      chk("rst_if_rvalid", if_rvalid, 1'b0);
      chk("rst_lsu_rvalid", lsu_rvalid, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
    end
    if (ei || el) begin
      chk("mem_addr", mem_addr, el ? la : ia);
      chk("mem_we", mem_we, el && lw);
      chk("mem_be", mem_be, (el && lw) ? lb : 4'hF);
      if (el && lw) chk("mem_wdata", mem_wdata, lwd);
      e.is_lsu  = el;
      e.is_read = !(el && lw);
      e.data    = ref_mem[(el ? la : ia) >> 2 & 32'h7F];
      sb.push_back(e);
    end
    if (el && lw)
      for (int b = 0; b < 4; b++)
        if (lb[b]) ref_mem[(la >> 2) & 32'h7F][8*b +: 8] = lwd[8*b +: 8];
    if_wait = (!rst || !ir || ei) ? 0 : if_wait + 1;
    last_ei = ei;
    last_el = el;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic        ir, lr, lw;
  logic [31:0] ia, la, lwd;
  logic [3:0]  lb;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i] = $urandom;
    end
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[64] = 32'hFFFF_FFFF;
    for (int i = 0; i < 128; i++) ref_mem[i] = ram[i];
    if_wait = 0;
    rstn = 1'b0; if_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = '0;
    if_addr = '0; lsu_addr = '0; lsu_wdata = '0;

    // Reset held with both requesting, then LSU wins the first free cycle.
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    chk("first_grant_lsu", lsu_gnt, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // IF streaming reads of 0x11, 0x22, 0x33.
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 32'(4 * k), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(1'b1);
    idle(1'b1);

    // LSU partial write then read-back of the merged word.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    idle(1'b1);
    chk("ram_merged_word", ram[64], 32'hFFFF_BEEF);
    idle(1'b1);

    // Both requesting continuously: IF forced through every LIMIT+1 cycles.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'(4 * k + 16), 32'h0);
      chk("starve_pattern", if_gnt, (k % (LIMIT + 1)) == LIMIT);
    end
    idle(1'b1);
    idle(1'b1);

    // Reset asserted in the cycle of an LSU grant while the counter is part-way up.
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    chk("pre_reset_lsu_gnt", lsu_gnt, 1'b1);
    #2;
    rstn = 1'b0;
    sb.delete();
    if_wait = 0;
    step(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    idle(1'b1);
    chk("no_rvalid_after_reset", lsu_rvalid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h48, 32'h0);
      chk("post_reset_counter", if_gnt, k == LIMIT);
    end
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic honouring the hold-until-granted handshake.
    ir = 1'b0; lr = 1'b0; ia = '0; la = '0; lw = 1'b0; lb = '0; lwd = '0;
    last_ei = 1'b0; last_el = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!(ir && !last_ei)) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = 32'($urandom_range(0, 127)) << 2;
      end
      if (!(lr && !last_el)) begin
        lr  = ($urandom_range(0, 99) < 70);
        lw  = 1'($urandom_range(0, 1));
        lb  = 4'($urandom_range(0, 15));
        la  = 32'($urandom_range(0, 127)) << 2;
        lwd = $urandom;
      end
      step(1'b1, ir, ia, lr, lw, lb, la, lwd);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
